// File: rtl/fpu_shift_arbiter.sv
// +----------------------------------------------------------------------------+
// | fpu_shift_arbiter: round-robin arbiter sharing one left barrel shifter     |
// | between two FPU requesters; right shifts via bit reversal.                 |
// | Optional sticky output enabled by macro FPU_SHIFT_ARB_STICKY_EN.           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module fpu_utils_shift #(
  parameter int DATA_WIDTH  = 77,
  parameter int SHAMT_WIDTH = 7
) (
  input  logic [DATA_WIDTH-1:0]  i_data,
  input  logic [SHAMT_WIDTH-1:0] i_shamt,
  output logic [DATA_WIDTH-1:0]  o_data
);
  // Shift amounts at or beyond the width naturally produce zero.
  assign o_data = i_data << i_shamt;
endmodule

module fpu_shift_arbiter #(
  parameter int DATA_WIDTH  = 77,
  parameter int SHAMT_WIDTH = 7,
  parameter int TAG_WIDTH   = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic [1:0]               req_valid_i,
  output logic [1:0]               req_ready_o,
  input  logic [2*DATA_WIDTH-1:0]  req_data_i,
  input  logic [2*SHAMT_WIDTH-1:0] req_shamt_i,
  input  logic [1:0]               req_dir_i,
  input  logic [2*TAG_WIDTH-1:0]   req_tag_i,
  output logic                     resp_valid_o,
  input  logic                     resp_ready_i,
  output logic [DATA_WIDTH-1:0]    resp_data_o,
  output logic [TAG_WIDTH-1:0]     resp_tag_o,
  output logic                     resp_src_o,
  output logic                     resp_sticky_o
);

  logic                   r_valid;
  logic [DATA_WIDTH-1:0]  r_data;
  logic [TAG_WIDTH-1:0]   r_tag;
  logic                   r_src;
  logic                   r_rr;

  logic                   w_can_acc;
  logic                   w_grant_vld;
  logic                   w_grant;
  logic                   w_accept;
  logic [DATA_WIDTH-1:0]  w_sel_data;
  logic [SHAMT_WIDTH-1:0] w_sel_shamt;
  logic                   w_sel_dir;
  logic [TAG_WIDTH-1:0]   w_sel_tag;
  logic [DATA_WIDTH-1:0]  w_rev_data;
  logic [DATA_WIDTH-1:0]  w_shl_in;
  logic [DATA_WIDTH-1:0]  w_shl_out;
  logic [DATA_WIDTH-1:0]  w_rev_out;
  logic [DATA_WIDTH-1:0]  w_shift_res;

  assign w_can_acc   = (!r_valid || resp_ready_i) && !flush_i && !rst_i;
  assign w_grant_vld = |req_valid_i;
  assign w_grant     = (req_valid_i == 2'b11) ? r_rr : req_valid_i[1];
  assign req_ready_o = {w_can_acc & w_grant_vld & w_grant,
                        w_can_acc & w_grant_vld & ~w_grant};
  assign w_accept    = |(req_valid_i & req_ready_o);

  assign w_sel_data  = w_grant ? req_data_i[2*DATA_WIDTH-1:DATA_WIDTH]
                               : req_data_i[DATA_WIDTH-1:0];
  assign w_sel_shamt = w_grant ? req_shamt_i[2*SHAMT_WIDTH-1:SHAMT_WIDTH]
                               : req_shamt_i[SHAMT_WIDTH-1:0];
  assign w_sel_tag   = w_grant ? req_tag_i[2*TAG_WIDTH-1:TAG_WIDTH]
                               : req_tag_i[TAG_WIDTH-1:0];
  assign w_sel_dir   = w_grant ? req_dir_i[1] : req_dir_i[0];

  // Right shift = reverse, shift left, reverse back.
  generate
    for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_rev
      assign w_rev_data[i] = w_sel_data[DATA_WIDTH-1-i];
      assign w_rev_out[i]  = w_shl_out[DATA_WIDTH-1-i];
    end
  endgenerate

  assign w_shl_in    = w_sel_dir ? w_rev_data : w_sel_data;
  assign w_shift_res = w_sel_dir ? w_rev_out : w_shl_out;

  fpu_utils_shift #(
    .DATA_WIDTH  (DATA_WIDTH),
    .SHAMT_WIDTH (SHAMT_WIDTH)
  ) u_shift (
    .i_data  (w_shl_in),
    .i_shamt (w_sel_shamt),
    .o_data  (w_shl_out)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_tag   <= '0;
      r_src   <= 1'b0;
      r_rr    <= 1'b0;
    end else if (w_accept) begin
      r_valid <= 1'b1;
      r_data  <= w_shift_res;
      r_tag   <= w_sel_tag;
      r_src   <= w_grant;
      r_rr    <= ~w_grant;
    end else if (flush_i || resp_ready_i) begin
      r_valid <= 1'b0;
    end
  end

`ifdef FPU_SHIFT_ARB_STICKY_EN
  logic                  r_sticky;
  logic [DATA_WIDTH-1:0] w_mask;
  logic                  w_sticky;

  // Mask marks the original bits that survive a right shift; the rest are lost.
  fpu_utils_shift #(
    .DATA_WIDTH  (DATA_WIDTH),
    .SHAMT_WIDTH (SHAMT_WIDTH)
  ) u_mask_shift (
    .i_data  ({DATA_WIDTH{1'b1}}),
    .i_shamt (w_sel_shamt),
    .o_data  (w_mask)
  );

  assign w_sticky = w_sel_dir & (|(w_sel_data & ~w_mask));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_sticky <= 1'b0;
    end else if (w_accept) begin
      r_sticky <= w_sticky;
    end
  end

  assign resp_sticky_o = r_sticky;
`else
  assign resp_sticky_o = 1'b0;
`endif

  assign resp_valid_o = r_valid;
  assign resp_data_o  = r_data;
  assign resp_tag_o   = r_tag;
  assign resp_src_o   = r_src;

endmodule

`default_nettype wire

// File: tb/tb_fpu_shift_arbiter.sv
// +----------------------------------------------------------------------------+
// | tb_fpu_shift_arbiter: directed scoreboard bench for fpu_shift_arbiter.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_fpu_shift_arbiter;

  localparam int DW = 77;
  localparam int SW = 7;
  localparam int TW = 4;
`ifdef FPU_SHIFT_ARB_STICKY_EN
  localparam logic STICKY_ON = 1'b1;
`else
  localparam logic STICKY_ON = 1'b0;
`endif

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic            flush_i;
  logic [1:0]      req_valid_i;
  logic [1:0]      req_ready_o;
  logic [2*DW-1:0] req_data_i;
  logic [2*SW-1:0] req_shamt_i;
  logic [1:0]      req_dir_i;
  logic [2*TW-1:0] req_tag_i;
  logic            resp_valid_o;
  logic            resp_ready_i;
  logic [DW-1:0]   resp_data_o;
  logic [TW-1:0]   resp_tag_o;
  logic            resp_src_o;
  logic            resp_sticky_o;

  fpu_shift_arbiter #(
    .DATA_WIDTH  (DW),
    .SHAMT_WIDTH (SW),
    .TAG_WIDTH   (TW)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .flush_i       (flush_i),
    .req_valid_i   (req_valid_i),
    .req_ready_o   (req_ready_o),
    .req_data_i    (req_data_i),
    .req_shamt_i   (req_shamt_i),
    .req_dir_i     (req_dir_i),
    .req_tag_i     (req_tag_i),
    .resp_valid_o  (resp_valid_o),
    .resp_ready_i  (resp_ready_i),
    .resp_data_o   (resp_data_o),
    .resp_tag_o    (resp_tag_o),
    .resp_src_o    (resp_src_o),
    .resp_sticky_o (resp_sticky_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [TW-1:0] t;
    logic          s;
    logic          st;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  logic [DW-1:0] v_data  [2];
  logic [SW-1:0] v_shamt [2];
  logic          v_dir   [2];
  logic [TW-1:0] v_tag   [2];
  logic [DW-1:0] e_data  [2];
  logic          e_st    [2];

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // One cycle of stimulus; checks ready/valid and records accepted requests.
  task automatic drive(input logic [1:0] v, input logic rr, input logic fl,
                       input logic [1:0] exp_rdy, input logic exp_vld);
    @(posedge clk_i); #1;
    req_valid_i  = v;
    resp_ready_i = rr;
    flush_i      = fl;
    req_data_i   = {v_data[1], v_data[0]};
    req_shamt_i  = {v_shamt[1], v_shamt[0]};
    req_dir_i    = {v_dir[1], v_dir[0]};
    req_tag_i    = {v_tag[1], v_tag[0]};
    @(negedge clk_i);
    chk("req_ready", 96'(req_ready_o), 96'(exp_rdy));
    chk("resp_valid", 96'(resp_valid_o), 96'(exp_vld));
    for (int n = 0; n < 2; n++)
      if (exp_rdy[n]) q.push_back('{d: e_data[n], t: v_tag[n], s: n[0], st: e_st[n]});
  endtask

  always @(negedge clk_i) begin
    if (!rst_i && resp_valid_o && resp_ready_i && !flush_i) begin
      if (q.size() == 0) begin
        chk("unexpected_resp", 96'(resp_valid_o), 96'(0));
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("resp_data", 96'(resp_data_o), 96'(e.d));
        chk("resp_tag", 96'(resp_tag_o), 96'(e.t));
        chk("resp_src", 96'(resp_src_o), 96'(e.s));
        chk("resp_sticky", 96'(resp_sticky_o), 96'(e.st));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    rst_i = 1'b1; flush_i = 1'b0; req_valid_i = 2'b11; resp_ready_i = 1'b0;
    req_data_i = '1; req_shamt_i = '0; req_dir_i = '0; req_tag_i = '1;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_valid", 96'(resp_valid_o), 96'(0));
    chk("rst_data", 96'(resp_data_o), 96'(0));
    chk("rst_tag", 96'(resp_tag_o), 96'(0));
    chk("rst_src", 96'(resp_src_o), 96'(0));
    chk("rst_sticky", 96'(resp_sticky_o), 96'(0));
    chk("rst_ready", 96'(req_ready_o), 96'(0));
    @(posedge clk_i); #1;
    req_valid_i = 2'b00;
    rst_i = 1'b0;

    // Requester 0: 1 << 76; requester 1: 3F >> 4 (bits 1111 lost).
    v_data[0] = 77'h1; v_shamt[0] = 7'd76; v_dir[0] = 1'b0; v_tag[0] = 4'h5;
    e_data[0] = 77'h1 << 76; e_st[0] = 1'b0;
    v_data[1] = 77'h3F; v_shamt[1] = 7'd4; v_dir[1] = 1'b1; v_tag[1] = 4'hA;
    e_data[1] = 77'h3; e_st[1] = STICKY_ON;
    drive(2'b11, 1'b1, 1'b0, 2'b01, 1'b0);
    drive(2'b10, 1'b1, 1'b0, 2'b10, 1'b1);
    v_shamt[1] = 7'd100; e_data[1] = '0; e_st[1] = STICKY_ON;
    drive(2'b10, 1'b1, 1'b0, 2'b10, 1'b1);

    // Contention: alternating grants, one result per cycle.
    v_data[0] = 77'hABCD; v_shamt[0] = 7'd8; v_dir[0] = 1'b0; v_tag[0] = 4'h1;
    e_data[0] = 77'hABCD00; e_st[0] = 1'b0;
    v_data[1] = 77'hF0F0; v_shamt[1] = 7'd4; v_dir[1] = 1'b1; v_tag[1] = 4'h2;
    e_data[1] = 77'hF0F; e_st[1] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(2'b11, 1'b1, 1'b0, 2'b01, 1'b1);
      drive(2'b11, 1'b1, 1'b0, 2'b10, 1'b1);
    end

    // Backpressure: last contention result (from requester 1) must hold.
    for (int i = 0; i < 3; i++) begin
      drive(2'b11, 1'b0, 1'b0, 2'b00, 1'b1);
      chk("stall_data", 96'(resp_data_o), 96'(77'hF0F));
      chk("stall_tag", 96'(resp_tag_o), 96'(4'h2));
      chk("stall_src", 96'(resp_src_o), 96'(1'b1));
    end
    drive(2'b11, 1'b1, 1'b0, 2'b01, 1'b1);

    // Flush with ready high drops the pending result and blocks accept.
    drive(2'b01, 1'b1, 1'b1, 2'b00, 1'b1);
    void'(q.pop_front());
    drive(2'b01, 1'b1, 1'b0, 2'b01, 1'b0);
    drive(2'b11, 1'b1, 1'b0, 2'b10, 1'b1);
    drive(2'b00, 1'b1, 1'b0, 2'b00, 1'b1);
    drive(2'b00, 1'b1, 1'b0, 2'b00, 1'b0);

    // Reset mid-transfer discards the in-flight result and clears the pointer.
    drive(2'b01, 1'b1, 1'b0, 2'b01, 1'b0);
    @(posedge clk_i); #2;
    rst_i = 1'b1;
    #1;
    chk("midrst_valid", 96'(resp_valid_o), 96'(0));
    chk("midrst_ready", 96'(req_ready_o), 96'(0));
    q.delete();
    req_valid_i = 2'b00;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    drive(2'b11, 1'b1, 1'b0, 2'b01, 1'b0);
    drive(2'b00, 1'b1, 1'b0, 2'b00, 1'b1);
    drive(2'b00, 1'b1, 1'b0, 2'b00, 1'b0);
    chk("queue_empty", 96'(q.size()), 96'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fpu_shift_arbiter.md
# fpu_shift_arbiter

Shares one barrel-shift datapath (a single left-mode `fpu_utils_shift` instance) between two FPU requesters, for example add/sub alignment and normalization. Each requester uses a valid/ready handshake. Grants alternate round-robin, and right shifts are executed by bit-reversing around the left shifter. The result passes through a single registered output stage with backpressure. The block sits between the FPU arithmetic pipelines and the shared shifter.

## Interface
- `DATA_WIDTH`, 77, operand/result width.
- `SHAMT_WIDTH`, 7, shift-amount width; shift amounts up to 2^SHAMT_WIDTH-1 are legal.
- `TAG_WIDTH`, 4, opaque tag carried with each request.
- `clk_i` input 1: clock, all state on rising edge.
- `rst_i` input 1: reset, asynchronous, active-high.
- `flush_i` input 1: synchronous flush of the output stage.
- `req_valid_i` input 2: request valid, bit n for requester n.
- `req_ready_o` output 2: request accepted this cycle when valid & ready.
- `req_data_i` input 2×DATA_WIDTH: operand per requester.
- `req_shamt_i` input 2×SHAMT_WIDTH: shift amount per requester.
- `req_dir_i` input 2: 0 = left, 1 = logical right.
- `req_tag_i` input 2×TAG_WIDTH: tag per requester.
- `resp_valid_o` output 1: result valid.
- `resp_ready_i` input 1: consumer accepts result.
- `resp_data_o` output DATA_WIDTH: shifted result.
- `resp_tag_o` output TAG_WIDTH: tag of the accepted request.
- `resp_src_o` output 1: index of the granted requester.
- `resp_sticky_o` output 1: OR of bits shifted out (see Configuration).

## Operation
- State:
  - output stage: `resp_valid_o`, data, tag, src, sticky;
  - round-robin pointer `rr_q` (1 bit, the requester favoured on conflict).
- Output slot free: `can_acc = !resp_valid_o | resp_ready_i`. It is forced to 0 while `flush_i` or `rst_i` is high.
- Grant:
  - Only one valid request: that requester is granted.
  - Both valid: requester `rr_q` is granted.
  - Otherwise: no grant.
- `req_ready_o[g] = can_acc & grant==g`. Ready may depend combinationally on `req_valid_i`. Ready is never high for both requesters in the same cycle.
- On accept: `rr_q <= ~g`. The output stage loads the shift result, tag, `src = g` and sticky, and `resp_valid_o <= 1`.
- Response drained with no accept: `resp_valid_o <= 0`. Data, tag, src and sticky hold their last values.
- Output stalled (`resp_valid_o & !resp_ready_i`): all response outputs hold stable.
- Arithmetic:
  - Left: result = data << shamt.
  - Right: result = data >> shamt, realised as reverse(reverse(data) << shamt).
  - Vacated bits are zero.
  - shamt ≥ DATA_WIDTH gives an all-zero result.
- Flush: `resp_valid_o <= 0` next edge. No request is accepted in the flush cycle. `rr_q` is unchanged.
- Reset values (asynchronous): `resp_valid_o` 0, `resp_data_o` 0, `resp_tag_o` 0, `resp_src_o` 0, `resp_sticky_o` 0, `rr_q` 0. `req_ready_o` is 0 while `rst_i` is high.

## Timing
- Latency: 1 cycle from the accept edge to `resp_valid_o`.
- Throughput: 1 result per cycle while `resp_ready_i` is held high (accept and drain in the same cycle).
- Stall: `resp_valid_o` high with `resp_ready_i` low drives both `req_ready_o` bits low.
- Fairness: under continuous contention, grants alternate 0,1,0,1…; neither requester waits more than 1 grant.
- `flush_i` and `resp_ready_i` high in the same cycle: flush wins. The result is dropped, with no double count.
- Reset asserted mid-transfer: an in-flight result is discarded. After release, the first contended grant goes to requester 0.

## Configuration
- Macro: `FPU_SHIFT_ARB_STICKY_EN`.
- Defined:
  - Right shifts: `resp_sticky_o` = OR of the bits shifted out. For shamt ≥ DATA_WIDTH it is the OR of all data bits.
  - Left shifts: sticky = 0.
  - Realisation: a second shifter instance produces the mask, and sticky = |(data & ~mask).
- Not defined: the mask shifter and sticky register are absent, and `resp_sticky_o` is tied to 0. The port list is unchanged.

## Test plan
- Reset:
  - Stimulus: `rst_i` pulsed with `req_valid_i`=2'b11.
  - Required: all outputs 0 and `req_ready_o`=0 during reset. The first grant after release goes to `resp_src_o`=0.
- Single left shift:
  - Stimulus: requester 0, data=77'h1, shamt=76, dir=0, tag=4'h5.
  - Required: next cycle `resp_valid_o`=1, data has bit 76 set, tag=5, src=0, sticky=0.
- Right shift with sticky (macro defined):
  - Stimulus: requester 1, data=77'h3F, shamt=4, dir=1.
  - Required: data=77'h3, sticky=1.
  - Stimulus: shamt=100.
  - Required: data=0, sticky=1.
  - Without the macro: sticky=0 in both cases.
- Contention:
  - Stimulus: both requesters valid for 6 cycles, `resp_ready_i`=1.
  - Required: `resp_src_o` sequence 0,1,0,1,0,1 and one result per cycle.
- Backpressure:
  - Stimulus: hold `resp_ready_i`=0 for 3 cycles with a response pending.
  - Required: response outputs stable, `req_ready_o`=0. On release, the held result is taken and the next request is accepted the same cycle.
- Flush:
  - Stimulus: `flush_i` with a valid response and `req_valid_i`=2'b01.
  - Required: `resp_valid_o`=0 next cycle, no accept in the flush cycle, requester 0 granted the cycle after.
